// File: rtl/hdmi_video_timing_ctrl.sv
// Video timing controller for the HDMI generator: raster counters, registered sync/DE decode,
// one-cycle-lookahead pixel request and a sticky pixel-source underflow flag.
module hdmi_video_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_pix_valid,
  input  logic        i_clr_underflow,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [1:0]  o_ctrl_ch0,
  output logic [1:0]  o_ctrl_ch1,
  output logic [1:0]  o_ctrl_ch2,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_pix_req,
  output logic        o_frame_start,
  output logic        o_line_start,
  output logic        o_underflow,
  output logic        o_busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_LO = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_HI = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_LO = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_HI = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_t;

  function automatic logic f_active(input logic [11:0] h, input logic [11:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  state_t      r_state, w_state_nxt;
  logic [11:0] r_h, r_v, w_h_nxt, w_v_nxt, w_h_inc, w_v_inc;
  logic [11:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic        r_de, r_hsync, r_vsync, r_pix_req, r_frame_start, r_line_start, r_underflow;
  logic        w_de_nxt, w_hsync_nxt, w_vsync_nxt, w_pix_req_nxt, w_fs_nxt, w_ls_nxt;
  logic        w_underflow_nxt;
  logic        w_h_wrap;

  always_comb begin
    w_h_wrap      = (r_h == H_LAST);
    w_h_inc       = w_h_wrap ? 12'd0 : r_h + 12'd1;
    w_v_inc       = w_h_wrap ? ((r_v == V_LAST) ? 12'd0 : r_v + 12'd1) : r_v;
    w_state_nxt   = r_state;
    w_h_nxt       = r_h;
    w_v_nxt       = r_v;
    w_de_nxt      = 1'b0;
    w_hsync_nxt   = ~H_POL;
    w_vsync_nxt   = ~V_POL;
    w_x_nxt       = 12'd0;
    w_y_nxt       = 12'd0;
    w_pix_req_nxt = 1'b0;
    w_fs_nxt      = 1'b0;
    w_ls_nxt      = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_h_nxt = 12'd0;
        w_v_nxt = 12'd0;
        if (i_enable) begin
          w_state_nxt   = StRun;
          w_pix_req_nxt = f_active(12'd0, 12'd0);
        end
      end
      StRun, StStopping: begin
        w_h_nxt       = w_h_inc;
        w_v_nxt       = w_v_inc;
        w_de_nxt      = f_active(r_h, r_v);
        w_hsync_nxt   = (r_h >= H_SYNC_LO && r_h <= H_SYNC_HI) ? H_POL : ~H_POL;
        w_vsync_nxt   = (r_v >= V_SYNC_LO && r_v <= V_SYNC_HI) ? V_POL : ~V_POL;
        w_x_nxt       = r_h;
        w_y_nxt       = r_v;
        w_fs_nxt      = (r_h == 12'd0) && (r_v == 12'd0);
        w_ls_nxt      = (r_h == 12'd0);
        // Lookahead: request for the position that the next edge will present.
        w_pix_req_nxt = f_active(w_h_inc, w_v_inc);
        if (r_state == StRun) begin
          if (!i_enable) w_state_nxt = StStopping;
        end else if (i_enable) begin
          w_state_nxt = StRun;
        end else if (w_h_wrap && (r_v == V_LAST)) begin
          w_state_nxt   = StIdle;
          w_pix_req_nxt = 1'b0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Set wins over clear; IDLE holds the flag at its reset value.
    if (r_state == StIdle)           w_underflow_nxt = 1'b0;
    else if (r_de && !i_pix_valid)   w_underflow_nxt = 1'b1;
    else if (i_clr_underflow)        w_underflow_nxt = 1'b0;
    else                             w_underflow_nxt = r_underflow;
  end

  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_h           <= 12'd0;
      r_v           <= 12'd0;
      r_de          <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_x           <= 12'd0;
      r_y           <= 12'd0;
      r_pix_req     <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_h           <= w_h_nxt;
      r_v           <= w_v_nxt;
      r_de          <= w_de_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_pix_req     <= w_pix_req_nxt;
      r_frame_start <= w_fs_nxt;
      r_line_start  <= w_ls_nxt;
      r_underflow   <= w_underflow_nxt;
    end
  end

  assign o_de          = r_de;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_ctrl_ch0    = {r_vsync, r_hsync};
  assign o_ctrl_ch1    = 2'b00;
  assign o_ctrl_ch2    = 2'b00;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_pix_req     = r_pix_req;
  assign o_frame_start = r_frame_start;
  assign o_line_start  = r_line_start;
  assign o_underflow   = r_underflow;
  assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_hdmi_video_timing_ctrl.sv
// Bench for hdmi_video_timing_ctrl with an 8x6 raster; expected outputs are queued per cycle
// from a raster-position model and compared when the DUT presents them.
module tb_hdmi_video_timing_ctrl;

  logic        i_pix_clk, i_rst, i_enable, i_pix_valid, i_clr_underflow;
  logic        o_de, o_hsync, o_vsync, o_pix_req, o_frame_start, o_line_start;
  logic        o_underflow, o_busy;
  logic [1:0]  o_ctrl_ch0, o_ctrl_ch1, o_ctrl_ch2;
  logic [11:0] o_x, o_y;

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut (
    .i_pix_clk      (i_pix_clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_pix_valid    (i_pix_valid),
    .i_clr_underflow(i_clr_underflow),
    .o_de           (o_de),
    .o_hsync        (o_hsync),
    .o_vsync        (o_vsync),
    .o_ctrl_ch0     (o_ctrl_ch0),
    .o_ctrl_ch1     (o_ctrl_ch1),
    .o_ctrl_ch2     (o_ctrl_ch2),
    .o_x            (o_x),
    .o_y            (o_y),
    .o_pix_req      (o_pix_req),
    .o_frame_start  (o_frame_start),
    .o_line_start   (o_line_start),
    .o_underflow    (o_underflow),
    .o_busy         (o_busy)
  );

  typedef struct packed {
    logic        de, hs, vs;
    logic [11:0] x, y;
    logic        pix_req, fs, ls, busy, und;
  } exp_t;

  exp_t  q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    g_cyc = 0;
  int    g_last_fs = 0;
  int    g_fs_period = 0;
  logic  g_prev_req = 1'b0;
  string g_name = "";

  initial i_pix_clk = 1'b0;
  always #5 i_pix_clk = ~i_pix_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic exp_t f_rst();
    exp_t e;
    e    = '0;
    e.hs = 1'b0;
    e.vs = 1'b0;
    return e;
  endfunction

  // Expected outputs while presenting raster position k (0..47 within a frame).
  function automatic exp_t f_pos(input int k);
    exp_t e;
    int   x, y, kn;
    x         = k % 8;
    y         = (k / 8) % 6;
    kn        = (k + 1) % 48;
    e         = '0;
    e.de      = (x < 4) && (y < 3);
    e.hs      = (x == 5) || (x == 6);
    e.vs      = (y == 4);
    e.x       = 12'(x);
    e.y       = 12'(y);
    e.fs      = (k % 48 == 0);
    e.ls      = (x == 0);
    e.pix_req = ((kn % 8) < 4) && ((kn / 8) < 3);
    e.busy    = 1'b1;
    return e;
  endfunction

  task automatic sb_check();
    exp_t e, a;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, no expected value", g_name);
    end else begin
      e = q.pop_front();
      a = {o_de, o_hsync, o_vsync, o_x, o_y, o_pix_req, o_frame_start, o_line_start, o_busy,
           o_underflow};
      n_vec++;
      if (a !== e || o_ctrl_ch0 !== {e.vs, e.hs} || o_ctrl_ch1 !== 2'b00 ||
          o_ctrl_ch2 !== 2'b00) begin
        n_err++;
        $display({"FAIL %s cyc %0d: got de%b hs%b vs%b x%0d y%0d req%b fs%b ls%b busy%b und%b ",
                  "ch0=%b ch1=%b ch2=%b; want de%b hs%b vs%b x%0d y%0d req%b fs%b ls%b busy%b ",
                  "und%b ch0=%b"},
                 g_name, g_cyc, a.de, a.hs, a.vs, a.x, a.y, a.pix_req, a.fs, a.ls, a.busy, a.und,
                 o_ctrl_ch0, o_ctrl_ch1, o_ctrl_ch2, e.de, e.hs, e.vs, e.x, e.y, e.pix_req, e.fs,
                 e.ls, e.busy, e.und, {e.vs, e.hs});
      end
    end
  endtask

  // Queue the expectation, advance one edge, then compare away from the edge.
  task automatic tick(input exp_t e);
    q.push_back(e);
    @(posedge i_pix_clk);
    #1;
    g_cyc++;
    sb_check();
    n_vec++;
    if ((g_prev_req && o_de !== 1'b1) || (o_de === 1'b1 && !g_prev_req)) begin
      n_err++;
      $display("FAIL %s lookahead cyc %0d: prev pix_req=%b de=%b, required equal", g_name, g_cyc,
               g_prev_req, o_de);
    end
    g_prev_req = o_pix_req;
    if (o_frame_start === 1'b1) begin
      g_fs_period = g_cyc - g_last_fs;
      g_last_fs   = g_cyc;
    end
  endtask

  task automatic tick_start();
    exp_t e;
    e         = f_rst();
    e.pix_req = 1'b1;
    e.busy    = 1'b1;
    tick(e);
  endtask

  task automatic test_reset();
    g_name          = "reset";
    i_rst           = 1'b1;
    i_enable        = 1'b0;
    i_pix_valid     = 1'b1;
    i_clr_underflow = 1'b0;
    #1;
    q.push_back(f_rst());
    sb_check();
    tick(f_rst());
    tick(f_rst());
    i_rst = 1'b0;
    tick(f_rst());
    tick(f_rst());
  endtask

  task automatic test_start();
    int n_de, n_req;
    g_name   = "start";
    n_de     = 0;
    n_req    = 0;
    i_enable = 1'b1;
    tick_start();
    for (int k = 0; k < 48; k++) begin
      tick(f_pos(k));
      n_de  += int'(o_de);
      n_req += int'(o_pix_req);
      if (k == 37) begin
        n_vec++;
        if (o_ctrl_ch0 !== 2'b11) begin
          n_err++;
          $display("FAIL vsync_ch0_5_4: got %b want 11", o_ctrl_ch0);
        end
      end
      if (k == 32) begin
        n_vec++;
        if (o_ctrl_ch0 !== 2'b10) begin
          n_err++;
          $display("FAIL vsync_ch0_0_4: got %b want 10", o_ctrl_ch0);
        end
      end
    end
    n_vec++;
    if (n_de != 12 || n_req != 12) begin
      n_err++;
      $display("FAIL frame_counts: de=%0d req=%0d want 12/12", n_de, n_req);
    end
  endtask

  task automatic test_stop_resume();
    g_name = "stop_resume";
    for (int k = 48; k < 96; k++) begin
      tick(f_pos(k));
      if (k == 48) begin
        n_vec++;
        if (g_fs_period != 48) begin
          n_err++;
          $display("FAIL period_run: got %0d want 48", g_fs_period);
        end
      end
      if (k == 58) i_enable = 1'b0;
      if (k == 72) i_enable = 1'b1;
    end
  endtask

  task automatic test_stop();
    exp_t e;
    g_name = "stop";
    for (int k = 96; k < 144; k++) begin
      e = f_pos(k);
      if (k == 143) begin
        e.busy    = 1'b0;
        e.pix_req = 1'b0;
      end
      tick(e);
      if (k == 96) begin
        n_vec++;
        if (g_fs_period != 48) begin
          n_err++;
          $display("FAIL period_resume: got %0d want 48", g_fs_period);
        end
      end
      if (k == 106) i_enable = 1'b0;
    end
    for (int i = 0; i < 3; i++) tick(f_rst());
  endtask

  task automatic test_underflow();
    exp_t e;
    logic u;
    g_name   = "underflow";
    u        = 1'b0;
    i_enable = 1'b1;
    tick_start();
    for (int k = 0; k < 20; k++) begin
      e     = f_pos(k);
      e.und = u;
      tick(e);
      i_pix_valid     = !(k == 2 || k == 9 || k == 14);
      i_clr_underflow = (k == 9 || k == 11);
      if (e.de && !i_pix_valid) u = 1'b1;
      else if (i_clr_underflow) u = 1'b0;
      if (k == 3) begin
        n_vec++;
        if (o_underflow !== 1'b1) begin
          n_err++;
          $display("FAIL underflow_set: got %b want 1", o_underflow);
        end
      end
    end
    i_pix_valid     = 1'b1;
    i_clr_underflow = 1'b0;
  endtask

  task automatic test_reset_mid();
    g_name = "reset_mid";
    // Currently presenting (3,2); enable stays high throughout.
    i_rst = 1'b1;
    #1;
    q.push_back(f_rst());
    sb_check();
    g_prev_req = 1'b0;
    tick(f_rst());
    i_rst = 1'b0;
    tick_start();
    for (int k = 0; k < 10; k++) tick(f_pos(k));
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop_resume();
    test_stop();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
